pipelined_addsub_unit: RTL and testbench
========================================

// Module: pipelined_addsub_unit
// PURPOSE
//   Parametrised, pipelined add/subtract unit with signed saturation and valid/ready handshakes.
//   Successor to the fixed 8-bit combinational adder behind the VIO top.
//   Splits a WIDTH-bit operation into STAGES registered carry-chained slices.
//   Sits between a stimulus source (VIO or upstream logic) and a result consumer,
//   and supports back-pressure.
// PARAMETERS
//   WIDTH   8   operand/result width in bits; must be divisible by STAGES
//   STAGES  2   pipeline depth = number of slices (>=1); slice width SW = WIDTH/STAGES
// PORTS
//   Clk        in   1      single clock, rising edge
//   Rst_n      in   1      asynchronous, active-low reset
//   In_valid   in   1      operand beat present
//   In_ready   out  1      unit accepts beat this cycle
//   A          in   WIDTH  operand A (two's complement in SAT modes)
//   B          in   WIDTH  operand B
//   Cin        in   1      carry-in (ADD) / borrow-in (SUB)
//   Mode       in   2      00 ADD, 01 SUB, 10 ADD_SAT, 11 SUB_SAT
//   Out_valid  out  1      result beat present
//   Out_ready  in   1      consumer accepts result
//   Sum        out  WIDTH  result
//   Cout       out  1      raw carry out of MSB (SUB: 1 = no borrow)
//   Overflow   out  1      signed overflow of the raw (unsaturated) result
//   Busy       out  1      any pipeline stage holds a valid beat
// BEHAVIOUR
// - Reset (async, Rst_n=0): all stage valids, Out_valid, Sum, Cout, Overflow and Busy go to 0
//   immediately. In-flight beats are discarded. Rst_n=1 -> first accept possible on the next edge.
// - Stall is global: advance = ~Out_valid | Out_ready. In_ready = advance (combinational from Out_ready).
//   A beat is accepted when In_valid & In_ready. The output beat is consumed when Out_valid & Out_ready.
// - Latency: accepted on edge k -> Out_valid on edge k+STAGES-1 (STAGES registered slices).
//   Throughput is 1 beat/cycle when Out_ready=1. Bubbles travel as invalid slots and are not collapsed.
// - Arithmetic:
//   - ADD: {Cout,R} = A + B + Cin.
//   - SUB: {Cout,R} = A + ~B + ~Cin, i.e. A - B - Cin.
//   - Slice i adds bits [i*SW +: SW] with the registered carry from slice i-1.
//   - Upper operand slices, Mode and A[MSB] are delayed alongside. Lower result slices are held in
//     skew registers so all WIDTH bits leave together.
// - Overflow = carry into MSB XOR carry out of MSB, computed in the last slice. Reported in all modes.
// - SAT modes: if Overflow, Sum = A_sign ? {1'b1,{WIDTH-1{0}}} : {1'b0,{WIDTH-1{1}}}; else Sum = R.
//   Cout stays raw.
// - Output register holds Sum/Cout/Overflow stable while Out_valid & ~Out_ready.
//   No beat is dropped or duplicated.
// - Input accept and output consume in the same cycle are allowed and keep throughput.
// - Mode/Cin/A/B are sampled only on accept. Values outside accept cycles are ignored.
// - STAGES=1: single registered stage, latency 1, no skew registers.
// STRUCTURE
// - Package addsub_pkg: Mode encodings MODE_ADD/MODE_SUB/MODE_ADD_SAT/MODE_SUB_SAT,
//   localparam function for saturation constants.
// - Sub-module addsub_slice (SW-bit adder + carry/valid register with enable), generated STAGES
//   times. The top holds the skew/delay registers, the saturation mux and handshake logic.
// - Elaboration check: WIDTH % STAGES != 0 or STAGES < 1 -> $error.
// TESTING (WIDTH=8, STAGES=2 unless stated)
// 1. ADD A=0x3C B=0x55 Cin=1, Out_ready=1 -> 1 cycle after accept: Sum=0x92, Cout=0, Overflow=1.
// 2. SUB A=0x10 B=0x20 Cin=0 -> Sum=0xF0, Cout=0 (borrow), Overflow=0.
// 3. ADD_SAT A=0x7F B=0x01 -> Sum=0x7F, Overflow=1.
//    SUB_SAT A=0x80 B=0x01 -> Sum=0x80, Overflow=1.
//    ADD_SAT A=0x05 B=0x03 -> Sum=0x08, Overflow=0.
// 4. Stream 6 beats (A=1..6, B=0x10, ADD) with Out_ready low for 3 cycles mid-stream
//    -> In_ready low while stalled, outputs 0x11..0x16 in order, none lost or duplicated,
//    Sum stable while stalled.
// 5. Pulse Rst_n=0 with 2 beats in flight -> Out_valid/Busy drop to 0 asynchronously.
//    After release the next beat A=0x01 B=0x01 yields 0x02, with no stale output.
// 6. WIDTH=16, STAGES=4: A=0xFFFF B=0x0001 ADD -> Sum=0x0000, Cout=1, Overflow=0,
//    Out_valid 3 cycles after accept.
//    Also run STAGES=1: same case, latency 1.

Source files
------------

// File: rtl/addsub_pkg.sv
// addsub_pkg: mode encodings and saturation constants for the pipelined add/sub unit
package addsub_pkg;
    typedef enum logic [1:0] {
        MODE_ADD     = 2'b00,
        MODE_SUB     = 2'b01,
        MODE_ADD_SAT = 2'b10,
        MODE_SUB_SAT = 2'b11
    } mode_e;
    // neg=1 -> most negative two's-complement value, neg=0 -> most positive
    function automatic logic [63:0] sat_const(input int width, input logic neg);
        return neg ? (64'd1 << (width - 1)) : ((64'd1 << (width - 1)) - 64'd1);
    endfunction
endpackage

// File: rtl/addsub_slice.sv
// addsub_slice: SW-bit adder slice with registered carry, valid and (last slice only) overflow
//   Clk, Rst_n : clock, async active-low reset
//   en         : pipeline advance
//   a, b, c_in : slice operands and carry-in (b already inverted for subtraction)
//   v_in       : beat valid entering this slice
//   sum        : combinational slice sum, registered by the parent
//   c_q, v_q   : registered carry-out and valid
//   ovf_q      : registered signed overflow, always 0 unless LAST
module addsub_slice #(
    parameter int SW   = 4,
    parameter bit LAST = 1'b0
) (
    input  logic          Clk,
    input  logic          Rst_n,
    input  logic          en,
    input  logic [SW-1:0] a,
    input  logic [SW-1:0] b,
    input  logic          c_in,
    input  logic          v_in,
    output logic [SW-1:0] sum,
    output logic          c_q,
    output logic          v_q,
    output logic          ovf_q
);
    logic c_d, ovf_d;
    always_comb begin
        {c_d, sum} = {1'b0, a} + {1'b0, b} + {{SW{1'b0}}, c_in};
        // carry into MSB is a^b^sum at the MSB; overflow when it differs from carry out
        ovf_d = LAST && (a[SW-1] ^ b[SW-1] ^ sum[SW-1] ^ c_d);
    end
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            c_q   <= 1'b0;
            v_q   <= 1'b0;
            ovf_q <= 1'b0;
        end else if (en) begin
            c_q   <= c_d;
            v_q   <= v_in;
            ovf_q <= ovf_d;
        end
    end
endmodule

// File: rtl/pipelined_addsub_unit.sv
// pipelined_addsub_unit: STAGES-deep carry-chained add/sub with signed saturation and valid/ready
//   Clk, Rst_n          : clock, async active-low reset
//   In_valid, In_ready  : operand handshake (In_ready = global advance)
//   A, B, Cin, Mode     : operands, carry/borrow-in, mode (ADD/SUB/ADD_SAT/SUB_SAT)
//   Out_valid, Out_ready: result handshake
//   Sum, Cout, Overflow : result, raw carry out, raw signed overflow
//   Busy                : any stage holds a valid beat
module pipelined_addsub_unit
    import addsub_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             In_valid,
    output logic             In_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic [1:0]       Mode,
    output logic             Out_valid,
    input  logic             Out_ready,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             Overflow,
    output logic             Busy
);
    localparam int SW = WIDTH / STAGES;
    localparam logic [WIDTH-1:0] SAT_MIN = WIDTH'(sat_const(WIDTH, 1'b1));
    localparam logic [WIDTH-1:0] SAT_MAX = WIDTH'(sat_const(WIDTH, 1'b0));

    if (STAGES < 1 || WIDTH % STAGES != 0) begin : g_bad_params
        $error("pipelined_addsub_unit: WIDTH must be divisible by STAGES and STAGES >= 1");
    end

    logic              advance, sub_in, sat_in, c_in;
    logic [WIDTH-1:0]  b_in;
    logic [STAGES-1:0] v_all, ovf_all;

    // subtraction is A + ~B + ~Cin, so inversion happens once at the input
    always_comb begin
        sub_in = (Mode == MODE_SUB) || (Mode == MODE_SUB_SAT);
        sat_in = (Mode == MODE_ADD_SAT) || (Mode == MODE_SUB_SAT);
        b_in   = sub_in ? ~B : B;
        c_in   = sub_in ? ~Cin : Cin;
    end

    for (genvar s = 0; s < STAGES; s++) begin : g_st
        // HI = operand B bits still pending when the beat enters stage s
        localparam int HI = WIDTH - s * SW;
        logic [WIDTH-1:0] a_d, r_d, r_q;
        logic [HI-1:0]    b_d;
        logic [SW-1:0]    sum;
        logic             c_d, v_d, sat_d, sg_d, sat_q, sg_q, c_q, v_q, ovf_q;
        if (s == 0) begin : g_first
            always_comb begin
                a_d   = A;
                b_d   = b_in;
                c_d   = c_in;
                v_d   = In_valid;
                sat_d = sat_in;
                sg_d  = A[WIDTH-1];
            end
        end else begin : g_next
            always_comb begin
                a_d   = g_st[s-1].r_q;
                b_d   = g_st[s-1].g_b.b_q;
                c_d   = g_st[s-1].c_q;
                v_d   = g_st[s-1].v_q;
                sat_d = g_st[s-1].sat_q;
                sg_d  = g_st[s-1].sg_q;
            end
        end
        addsub_slice #(.SW(SW), .LAST(s == STAGES - 1)) u_slice (
            .Clk   (Clk),
            .Rst_n (Rst_n),
            .en    (advance),
            .a     (a_d[s*SW +: SW]),
            .b     (b_d[SW-1:0]),
            .c_in  (c_d),
            .v_in  (v_d),
            .sum   (sum),
            .c_q   (c_q),
            .v_q   (v_q),
            .ovf_q (ovf_q)
        );
        // one vector carries finished result slices below s and untouched A slices above
        always_comb begin
            r_d              = a_d;
            r_d[s*SW +: SW]  = sum;
        end
        always_ff @(posedge Clk or negedge Rst_n) begin
            if (!Rst_n) begin
                r_q   <= '0;
                sat_q <= 1'b0;
                sg_q  <= 1'b0;
            end else if (advance) begin
                r_q   <= r_d;
                sat_q <= sat_d;
                sg_q  <= sg_d;
            end
        end
        if (s < STAGES - 1) begin : g_b
            logic [HI-SW-1:0] b_q;
            always_ff @(posedge Clk or negedge Rst_n) begin
                if (!Rst_n) b_q <= '0;
                else if (advance) b_q <= b_d[HI-1:SW];
            end
        end
        assign v_all[s]   = v_q;
        assign ovf_all[s] = ovf_q;
    end

    // only the last slice reports overflow, the others hold 0
    always_comb begin
        Out_valid = g_st[STAGES-1].v_q;
        advance   = !Out_valid || Out_ready;
        In_ready  = advance;
        Busy      = |v_all;
        Cout      = g_st[STAGES-1].c_q;
        Overflow  = |ovf_all;
        Sum       = (g_st[STAGES-1].sat_q && Overflow)
                  ? (g_st[STAGES-1].sg_q ? SAT_MIN : SAT_MAX)
                  : g_st[STAGES-1].r_q;
    end
endmodule

// File: tb/tb_pipelined_addsub_unit.sv
// tb_pipelined_addsub_unit: scoreboard bench for the pipelined add/sub unit
module tb_pipelined_addsub_unit;
    import addsub_pkg::*;

    logic       clk = 1'b0, rst_n = 1'b0;
    logic       in_valid = 1'b0, cin = 1'b0, out_ready = 1'b1;
    logic [7:0] a = '0, b = '0;
    logic [1:0] mode = 2'b00;
    logic       in_ready, out_valid, cout, ovf, busy;
    logic [7:0] sum;

    logic        w_valid = 1'b0, w_cin = 1'b0, w_rdy = 1'b1;
    logic [15:0] w_a = '0, w_b = '0;
    logic [1:0]  w_mode = 2'b00;
    logic        w_iready, w_ov, w_cout, w_ovf, w_busy;
    logic [15:0] w_sum;

    logic       s_valid = 1'b0, s_cin = 1'b0, s_rdy = 1'b1;
    logic [7:0] s_a = '0, s_b = '0;
    logic [1:0] s_mode = 2'b00;
    logic       s_iready, s_ov, s_cout, s_ovf, s_busy;
    logic [7:0] s_sum;

    int errors = 0, checks = 0, consumed = 0;
    logic [9:0] exp_q[$];
    logic [9:0] e;

    always #5 clk = ~clk;

    pipelined_addsub_unit #(.WIDTH(8), .STAGES(2)) dut (
        .Clk(clk), .Rst_n(rst_n), .In_valid(in_valid), .In_ready(in_ready), .A(a), .B(b),
        .Cin(cin), .Mode(mode), .Out_valid(out_valid), .Out_ready(out_ready), .Sum(sum),
        .Cout(cout), .Overflow(ovf), .Busy(busy));

    pipelined_addsub_unit #(.WIDTH(16), .STAGES(4)) dut4 (
        .Clk(clk), .Rst_n(rst_n), .In_valid(w_valid), .In_ready(w_iready), .A(w_a), .B(w_b),
        .Cin(w_cin), .Mode(w_mode), .Out_valid(w_ov), .Out_ready(w_rdy), .Sum(w_sum),
        .Cout(w_cout), .Overflow(w_ovf), .Busy(w_busy));

    pipelined_addsub_unit #(.WIDTH(8), .STAGES(1)) dut1 (
        .Clk(clk), .Rst_n(rst_n), .In_valid(s_valid), .In_ready(s_iready), .A(s_a), .B(s_b),
        .Cin(s_cin), .Mode(s_mode), .Out_valid(s_ov), .Out_ready(s_rdy), .Sum(s_sum),
        .Cout(s_cout), .Overflow(s_ovf), .Busy(s_busy));

    // reference: {overflow, cout, sum}; overflow from operand/result signs
    function automatic logic [9:0] model(input logic [7:0] ma, mb, input logic mc, input logic [1:0] mm);
        logic [7:0] bb, r;
        logic [8:0] full;
        logic       ov;
        bb   = mm[0] ? ~mb : mb;
        full = {1'b0, ma} + {1'b0, bb} + {8'd0, mm[0] ? ~mc : mc};
        r    = full[7:0];
        ov   = (ma[7] == bb[7]) && (r[7] != ma[7]);
        return {ov, full[8], (mm[1] && ov) ? (ma[7] ? 8'h80 : 8'h7F) : r};
    endfunction

    // inputs change only at negedge; handshakes sampled 1ns later
    always @(negedge clk) begin
        #1;
        if (rst_n) begin
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_extra: unexpected output sum=%h cout=%b ovf=%b", sum, cout, ovf);
                end else begin
                    e = exp_q.pop_front();
                    consumed++;
                    if ({ovf, cout, sum} !== e)
                        begin errors++; $display("FAIL sb_result: got ovf=%b cout=%b sum=%h, expected ovf=%b cout=%b sum=%h", ovf, cout, sum, e[9], e[8], e[7:0]); end
                end
            end
            if (in_valid && in_ready) exp_q.push_back(model(a, b, cin, mode));
        end
    end

    task automatic beat(input logic [7:0] ta, tb, input logic tc, input logic [1:0] tm);
        @(negedge clk);
        in_valid = 1'b1; a = ta; b = tb; cin = tc; mode = tm;
    endtask

    task automatic drain();
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 30 && exp_q.size() != 0; i++) @(negedge clk);
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b, expected 0", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b, expected 0", busy); end
        checks++; if ({ovf, cout, sum} !== 10'd0) begin errors++; $display("FAIL rst_outputs: got ovf=%b cout=%b sum=%h, expected 0", ovf, cout, sum); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b, expected 1", in_ready); end
        checks++; if ({w_ov, w_busy, s_ov, s_busy} !== 4'b0) begin errors++; $display("FAIL rst_other: got %b, expected 0000", {w_ov, w_busy, s_ov, s_busy}); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_add();
        beat(8'h3C, 8'h55, 1'b1, MODE_ADD);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL add_early: out_valid=%b, expected 0", out_valid); end
        @(negedge clk);
        #1;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL add_latency: out_valid=%b, expected 1", out_valid); end
        checks++; if (sum !== 8'h92) begin errors++; $display("FAIL add_sum: got %h, expected 92", sum); end
        checks++; if (cout !== 1'b0) begin errors++; $display("FAIL add_cout: got %b, expected 0", cout); end
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL add_ovf: got %b, expected 1", ovf); end
    endtask

    task automatic test_sub_sat();
        int c0;
        c0 = consumed;
        beat(8'h10, 8'h20, 1'b0, MODE_SUB);
        beat(8'h7F, 8'h01, 1'b0, MODE_ADD_SAT);
        beat(8'h80, 8'h01, 1'b0, MODE_SUB_SAT);
        beat(8'h05, 8'h03, 1'b0, MODE_ADD_SAT);
        drain();
        checks++; if (consumed - c0 != 4) begin errors++; $display("FAIL subsat_count: got %0d beats, expected 4", consumed - c0); end
    endtask

    task automatic test_back_to_back();
        int         n;
        logic       held_v;
        logic [7:0] held;
        n = 1; held_v = 1'b0; held = '0; consumed = 0;
        for (int cyc = 0; cyc < 16; cyc++) begin
            @(negedge clk);
            out_ready = !(cyc >= 3 && cyc < 6);
            in_valid  = (n <= 6); a = 8'(n); b = 8'h10; cin = 1'b0; mode = MODE_ADD;
            #1;
            if (!out_ready && out_valid) begin
                checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_ready: in_ready=%b, expected 0", in_ready); end
                if (held_v) begin
                    checks++; if (sum !== held) begin errors++; $display("FAIL stall_hold: sum=%h, expected %h", sum, held); end
                end
                held_v = 1'b1; held = sum;
            end
            if (in_valid && in_ready) n++;
        end
        drain();
        checks++; if (consumed != 6) begin errors++; $display("FAIL stream_count: got %0d beats, expected 6", consumed); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL stream_left: %0d beats pending, expected 0", exp_q.size()); end
    endtask

    task automatic test_reset_inflight();
        int got;
        beat(8'h21, 8'h02, 1'b0, MODE_ADD);
        beat(8'h33, 8'h04, 1'b0, MODE_ADD);
        @(negedge clk);
        in_valid = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL arst_valid: got %b, expected 0", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL arst_busy: got %b, expected 0", busy); end
        exp_q.delete();
        #1;
        rst_n = 1'b1;
        beat(8'h01, 8'h01, 1'b0, MODE_ADD);
        got = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            #1;
            if (out_valid) begin got = 1; break; end
        end
        checks++; if (got != 1) begin errors++; $display("FAIL arst_timeout: no output after reset, expected one"); end
        checks++; if (sum !== 8'h02) begin errors++; $display("FAIL arst_sum: got %h, expected 02", sum); end
        drain();
    endtask

    task automatic test_random();
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            in_valid  = $urandom_range(0, 3) != 0;
            a         = 8'($urandom);
            b         = 8'($urandom);
            cin       = 1'($urandom);
            mode      = 2'($urandom);
            out_ready = $urandom_range(0, 3) != 0;
        end
        drain();
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL random_left: %0d beats pending, expected 0", exp_q.size()); end
    endtask

    task automatic test_wide();
        int lat;
        @(negedge clk);
        w_valid = 1'b1; w_a = 16'hFFFF; w_b = 16'h0001; w_cin = 1'b0; w_mode = MODE_ADD;
        lat = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            w_valid = 1'b0;
            #1;
            if (w_ov) begin lat = i; break; end
        end
        checks++; if (lat != 4) begin errors++; $display("FAIL wide_latency: got %0d, expected 4", lat); end
        checks++; if ({w_ovf, w_cout, w_sum} !== {1'b0, 1'b1, 16'h0000}) begin errors++; $display("FAIL wide_result: got ovf=%b cout=%b sum=%h, expected ovf=0 cout=1 sum=0000", w_ovf, w_cout, w_sum); end
    endtask

    task automatic test_single();
        int lat;
        @(negedge clk);
        s_valid = 1'b1; s_a = 8'hFF; s_b = 8'h01; s_cin = 1'b0; s_mode = MODE_ADD;
        lat = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            s_valid = 1'b0;
            #1;
            if (s_ov) begin lat = i; break; end
        end
        checks++; if (lat != 1) begin errors++; $display("FAIL single_latency: got %0d, expected 1", lat); end
        checks++; if ({s_ovf, s_cout, s_sum} !== {1'b0, 1'b1, 8'h00}) begin errors++; $display("FAIL single_result: got ovf=%b cout=%b sum=%h, expected ovf=0 cout=1 sum=00", s_ovf, s_cout, s_sum); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_add();
        drain();
        test_sub_sat();
        test_back_to_back();
        test_reset_inflight();
        test_random();
        test_wide();
        test_single();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
